// File: rtl/am_mod_ctrl_if.sv
// Host configuration channel for am_mod_ctrl: a single valid/ready transfer
// carries both phase-increment words and the target modulation depth.
interface am_mod_ctrl_if #(
    parameter int PHASE_W = 32,
    parameter int GAIN_W  = 8
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [PHASE_W-1:0] cfg_car_inc;
    logic [PHASE_W-1:0] cfg_msg_inc;
    logic [GAIN_W-1:0]  cfg_depth;

    modport master (output cfg_valid, cfg_car_inc, cfg_msg_inc, cfg_depth, input cfg_ready);
    modport slave  (input cfg_valid, cfg_car_inc, cfg_msg_inc, cfg_depth, output cfg_ready);
endinterface

// File: rtl/am_mod_ctrl.sv
// Run-time controller for the AM modulator: owns the DDS increments and message gain,
// soft-ramping the gain on start/stop/retune. Define AM_SOFT_RAMP_EN for stepped ramps.
module am_mod_ctrl #(
    parameter int PHASE_W   = 32,
    parameter int GAIN_W    = 8,
    parameter int RAMP_DIV  = 64,
    parameter int RAMP_STEP = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    am_mod_ctrl_if.slave       host,
    output logic [PHASE_W-1:0] car_inc,
    output logic [PHASE_W-1:0] msg_inc,
    output logic [GAIN_W-1:0]  gain,
    output logic               dds_en,
    output logic               busy,
    output logic [1:0]         state
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] car_q, car_d, msg_q, msg_d;
    logic [PHASE_W-1:0] sh_car_q, sh_car_d, sh_msg_q, sh_msg_d;
    logic [GAIN_W-1:0]  gain_q, gain_d, target_q, target_d, sh_depth_q, sh_depth_d;
    logic               pending_q, pending_d, loaded_q, loaded_d, stop_req_q, stop_req_d;
    logic               dds_en_q, dds_en_d, busy_q, busy_d, ready_q, ready_d;
    logic               xfer, apply, ramp_tick, stop_now;
    logic [GAIN_W-1:0]  up_gain, down_gain;
`ifdef AM_SOFT_RAMP_EN
    localparam int PRESC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    logic [PRESC_W-1:0] presc_q, presc_d;
`endif

    assign xfer     = host.cfg_valid & ready_q;
    assign stop_now = stop | stop_req_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        gain_d     = gain_q;
        target_d   = target_q;
        car_d      = car_q;
        msg_d      = msg_q;
        sh_car_d   = sh_car_q;
        sh_msg_d   = sh_msg_q;
        sh_depth_d = sh_depth_q;
        loaded_d   = loaded_q;
        stop_req_d = stop_req_q;
        dds_en_d   = dds_en_q;
        apply      = 1'b0;
`ifdef AM_SOFT_RAMP_EN
        ramp_tick = (presc_q == PRESC_W'(RAMP_DIV - 1));
        up_gain   = (32'(gain_q) + 32'(RAMP_STEP) >= 32'(target_q)) ?
                    target_q : gain_q + GAIN_W'(RAMP_STEP);
        down_gain = (32'(gain_q) <= 32'(RAMP_STEP)) ? '0 : gain_q - GAIN_W'(RAMP_STEP);
`else
        ramp_tick = 1'b1;
        up_gain   = target_q;
        down_gain = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (start && !stop && (pending_q || loaded_q)) begin
                    apply    = pending_q;
                    dds_en_d = 1'b1;
                    state_d  = RAMP_UP;
                end
            end
            RAMP_UP: begin
                if (stop) begin
                    stop_req_d = 1'b1;
                    state_d    = RAMP_DOWN;
                end else if (gain_q == target_q) begin
                    state_d = RUN;
                end else if (ramp_tick) begin
                    gain_d = up_gain;
                end
            end
            RUN: begin
                if (stop) begin
                    stop_req_d = 1'b1;
                    state_d    = RAMP_DOWN;
                end else if (pending_q) begin
                    state_d = RAMP_DOWN;
                end
            end
            RAMP_DOWN: begin
                // Increments may only change here, with the multiplier input at zero.
                if (gain_q == '0) begin
                    if (stop_now) begin
                        stop_req_d = 1'b0;
                        dds_en_d   = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        apply   = pending_q;
                        state_d = RAMP_UP;
                    end
                end else begin
                    if (stop) stop_req_d = 1'b1;
                    if (ramp_tick) gain_d = down_gain;
                end
            end
        endcase

        if (apply) begin
            car_d    = sh_car_q;
            msg_d    = sh_msg_q;
            target_d = sh_depth_q;
            loaded_d = 1'b1;
        end
        if (xfer) begin
            sh_car_d   = host.cfg_car_inc;
            sh_msg_d   = host.cfg_msg_inc;
            sh_depth_d = host.cfg_depth;
        end
        pending_d = (pending_q & ~apply) | xfer;
        ready_d   = ~pending_d;
        busy_d    = (state_d != IDLE);
`ifdef AM_SOFT_RAMP_EN
        if (state_d != state_q || state_q == IDLE || state_q == RUN || ramp_tick) presc_d = '0;
        else presc_d = presc_q + PRESC_W'(1);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the shadow words are plain flops, not a RAM, so they take the async reset too.
        if (!rst_n) begin
            state_q    <= IDLE;
            gain_q     <= '0;
            target_q   <= '0;
            car_q      <= '0;
            msg_q      <= '0;
            sh_car_q   <= '0;
            sh_msg_q   <= '0;
            sh_depth_q <= '0;
            pending_q  <= 1'b0;
            loaded_q   <= 1'b0;
            stop_req_q <= 1'b0;
            dds_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
`ifdef AM_SOFT_RAMP_EN
            presc_q    <= '0;
`endif
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q    <= state_d;
            gain_q     <= gain_d;
            target_q   <= target_d;
            car_q      <= car_d;
            msg_q      <= msg_d;
            sh_car_q   <= sh_car_d;
            sh_msg_q   <= sh_msg_d;
            sh_depth_q <= sh_depth_d;
            pending_q  <= pending_d;
            loaded_q   <= loaded_d;
            stop_req_q <= stop_req_d;
            dds_en_q   <= dds_en_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
`ifdef AM_SOFT_RAMP_EN
            presc_q    <= presc_d;
`endif
        end
    end

    ramp_param_ok: assert property (@(posedge clk) (RAMP_DIV >= 1) && (RAMP_STEP >= 1));

    assign host.cfg_ready = ready_q;
    assign car_inc        = car_q;
    assign msg_inc        = msg_q;
    assign gain           = gain_q;
    assign dds_en         = dds_en_q;
    assign busy           = busy_q;
    assign state          = state_q;
endmodule

// File: tb/tb_am_mod_ctrl.sv
// Self-checking bench for am_mod_ctrl: directed scenarios plus random traffic, compared
// every cycle against a closed-form ramp model with a queue-based config shadow.
`timescale 1ns/1ps
module tb_am_mod_ctrl;
    localparam int PHASE_W   = 32;
    localparam int GAIN_W    = 8;
    localparam int RAMP_DIV  = 4;
    localparam int RAMP_STEP = 4;
`ifdef AM_SOFT_RAMP_EN
    localparam bit SOFT     = 1'b1;
    localparam int EFF_DIV  = RAMP_DIV;
    localparam int EFF_STEP = RAMP_STEP;
`else
    localparam bit SOFT     = 1'b0;
    localparam int EFF_DIV  = 1;
    localparam int EFF_STEP = 1 << GAIN_W;
`endif
    localparam int S_IDLE = 0, S_UP = 1, S_RUN = 2, S_DOWN = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic [PHASE_W-1:0] car_inc, msg_inc;
    logic [GAIN_W-1:0]  gain;
    logic               dds_en, busy;
    logic [1:0]         state;

    am_mod_ctrl_if #(.PHASE_W(PHASE_W), .GAIN_W(GAIN_W)) bus ();

    am_mod_ctrl #(
        .PHASE_W(PHASE_W), .GAIN_W(GAIN_W), .RAMP_DIV(RAMP_DIV), .RAMP_STEP(RAMP_STEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .host(bus),
        .car_inc(car_inc), .msg_inc(msg_inc), .gain(gain),
        .dds_en(dds_en), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PHASE_W-1:0] car;
        logic [PHASE_W-1:0] msg;
        int                 depth;
    } cfg_t;

    // Reference model: the shadow is a queue holding at most one offer; gain during a
    // ramp is a closed-form function of the cycles spent in that ramp.
    cfg_t               shadow_q[$];
    int                 m_phase, m_n, m_g0, m_gain, m_target;
    logic [PHASE_W-1:0] m_car, m_msg;
    bit                 m_loaded, m_stop_req, m_dds, m_ready;
    int                 n_checks = 0;
    int                 n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        shadow_q.delete();
        m_phase = S_IDLE; m_n = 0; m_g0 = 0; m_gain = 0; m_target = 0;
        m_car = '0; m_msg = '0;
        m_loaded = 0; m_stop_req = 0; m_dds = 0; m_ready = 0;
    endtask

    task automatic model_apply();
        cfg_t c;
        if (shadow_q.size() > 0) begin
            c = shadow_q.pop_front();
            m_car = c.car; m_msg = c.msg; m_target = c.depth;
            m_loaded = 1;
        end
    endtask

    task automatic model_step();
        bit   xfer;
        int   nxt;
        cfg_t offer;
        xfer  = bus.cfg_valid && m_ready;
        offer = '{car: bus.cfg_car_inc, msg: bus.cfg_msg_inc, depth: int'(bus.cfg_depth)};
        nxt   = m_phase;
        case (m_phase)
            S_IDLE: if (start && !stop && (shadow_q.size() > 0 || m_loaded)) begin
                model_apply(); m_dds = 1; nxt = S_UP;
            end
            S_UP: begin
                if (stop) begin m_stop_req = 1; nxt = S_DOWN; end
                else if (m_gain == m_target) nxt = S_RUN;
            end
            S_RUN: begin
                if (stop) begin m_stop_req = 1; nxt = S_DOWN; end
                else if (shadow_q.size() > 0) nxt = S_DOWN;
            end
            default: begin
                if (m_gain == 0) begin
                    if (m_stop_req || stop) begin nxt = S_IDLE; m_dds = 0; m_stop_req = 0; end
                    else begin model_apply(); nxt = S_UP; end
                end else if (stop) m_stop_req = 1;
            end
        endcase
        if (xfer) shadow_q.push_back(offer);
        if (nxt != m_phase) begin
            m_phase = nxt; m_n = 0; m_g0 = m_gain;
        end else if (m_phase == S_UP) begin
            m_n++;
            m_gain = m_g0 + EFF_STEP * (m_n / EFF_DIV);
            if (m_gain > m_target) m_gain = m_target;
        end else if (m_phase == S_DOWN) begin
            m_n++;
            m_gain = m_g0 - EFF_STEP * (m_n / EFF_DIV);
            if (m_gain < 0) m_gain = 0;
        end
        m_ready = (shadow_q.size() == 0);
    endtask

    task automatic compare_all();
        check("state", 64'(state), 64'(m_phase));
        check("gain", 64'(gain), 64'(m_gain));
        check("car_inc", 64'(car_inc), 64'(m_car));
        check("msg_inc", 64'(msg_inc), 64'(m_msg));
        check("dds_en", 64'(dds_en), 64'(m_dds));
        check("busy", 64'(busy), 64'(m_phase != S_IDLE));
        check("cfg_ready", 64'(bus.cfg_ready), 64'(m_ready));
    endtask

    task automatic tick();
        bit acc;
        acc = bus.cfg_valid && m_ready;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        start = 0;
        stop  = 0;
        if (acc) bus.cfg_valid = 0;
    endtask

    task automatic send_cfg(input logic [31:0] car, input logic [31:0] msg, input logic [7:0] depth);
        int t;
        bus.cfg_car_inc = car; bus.cfg_msg_inc = msg; bus.cfg_depth = depth;
        bus.cfg_valid   = 1;
        t = 0;
        while (bus.cfg_valid && t < 2000) begin tick(); t++; end
        check("cfg_accepted", 64'(bus.cfg_valid), 64'd0);
    endtask

    task automatic wait_state(input int s, input int budget, output int t);
        t = 0;
        while (int'(state) != s && t < budget) begin tick(); t++; end
        check("wait_state", 64'(state), 64'(s));
    endtask

    initial begin
        int t;
        bus.cfg_valid = 0; bus.cfg_car_inc = '0; bus.cfg_msg_inc = '0; bus.cfg_depth = '0;
        model_reset();
        #1 rst_n = 0;
        #11;
        check("rst_state", 64'(state), 64'd0);
        check("rst_gain", 64'(gain), 64'd0);
        check("rst_dds_en", 64'(dds_en), 64'd0);
        check("rst_ready", 64'(bus.cfg_ready), 64'd0);
        @(negedge clk) rst_n = 1;
        tick();
        check("ready_after_rst", 64'(bus.cfg_ready), 64'd1);

        // Start with nothing configured is ignored.
        start = 1; tick();
        check("start_no_cfg_state", 64'(state), 64'd0);

        // Simultaneous start and stop: stop wins.
        send_cfg(32'h0100_0000, 32'h0001_0000, 8'h80);
        start = 1; stop = 1; tick();
        check("start_stop_state", 64'(state), 64'd0);
        check("start_stop_dds", 64'(dds_en), 64'd0);

        // Start and ramp to depth 0x80.
        start = 1; tick();
        check("up_state", 64'(state), 64'd1);
        check("up_car", 64'(car_inc), 64'h0100_0000);
        check("up_msg", 64'(msg_inc), 64'h0001_0000);
        check("up_dds", 64'(dds_en), 64'd1);
        t = 0;
        while (int'(state) != S_RUN && t < 1000) begin
            tick(); t++;
            if (t == 4) check("gain_after_4", 64'(gain), SOFT ? 64'd4 : 64'h80);
        end
        check("ramp_up_cycles", 64'(t), SOFT ? 64'd129 : 64'd2);
        check("run_gain", 64'(gain), 64'h80);

        // Retune while running.
        send_cfg(32'h0200_0000, 32'h0001_0000, 8'h40);
        check("retune_ready_low", 64'(bus.cfg_ready), 64'd0);
        wait_state(S_DOWN, 5, t);
        wait_state(S_RUN, 2000, t);
        check("retune_gain", 64'(gain), 64'h40);
        check("retune_car", 64'(car_inc), 64'h0200_0000);
        check("retune_ready", 64'(bus.cfg_ready), 64'd1);

        // Stop, restart, and stop again mid ramp-up.
        stop = 1; tick();
        wait_state(S_IDLE, 2000, t);
        start = 1; tick();
        t = 0;
        while (gain < 8'h20 && int'(state) == S_UP && t < 500) begin tick(); t++; end
        stop = 1; tick();
        check("stop_up_state", 64'(state), 64'd3);
        t = 0;
        while (int'(state) != S_IDLE && t < 1000) begin tick(); t++; end
        check("ramp_down_cycles", 64'(t), SOFT ? 64'd33 : 64'd2);
        check("stop_gain", 64'(gain), 64'd0);
        check("stop_dds", 64'(dds_en), 64'd0);

        // Depth not a multiple of the step.
        send_cfg(32'h0100_0000, 32'h0001_0000, 8'h7E);
        start = 1; tick();
        wait_state(S_RUN, 2000, t);
        check("sat_gain", 64'(gain), 64'h7E);
        stop = 1; tick();
        wait_state(S_IDLE, 2000, t);
        check("sat_down_gain", 64'(gain), 64'd0);

        // Asynchronous reset mid-run.
        send_cfg(32'h0100_0000, 32'h0001_0000, 8'h80);
        start = 1; tick();
        wait_state(S_RUN, 2000, t);
        check("pre_rst_gain", 64'(gain), 64'h80);
        #2 rst_n = 0;
        #1;
        check("arst_state", 64'(state), 64'd0);
        check("arst_gain", 64'(gain), 64'd0);
        check("arst_car", 64'(car_inc), 64'd0);
        check("arst_dds", 64'(dds_en), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk) rst_n = 1;
        tick();
        check("ready_after_arst", 64'(bus.cfg_ready), 64'd1);
        start = 1; tick();
        check("start_after_arst", 64'(state), 64'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if (!bus.cfg_valid && $urandom_range(0, 7) == 0) begin
                bus.cfg_car_inc = $urandom;
                bus.cfg_msg_inc = $urandom;
                case ($urandom_range(0, 3))
                    0:       bus.cfg_depth = 8'h00;
                    1:       bus.cfg_depth = 8'h7E;
                    2:       bus.cfg_depth = 8'hFF;
                    default: bus.cfg_depth = 8'($urandom);
                endcase
                bus.cfg_valid = 1;
            end
            start = ($urandom_range(0, 29) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
